// File: rtl/i2c_pkg.sv
// Shared definitions for the configuration-bus I2C target: FSM encoding,
// bus-level constants and the open-drain drive helper.
package i2c_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_PTR,
      ST_PTR_ACK,
      ST_WDATA,
      ST_WDATA_ACK,
      ST_RDATA,
      ST_RDATA_ACK,
      ST_WAIT_STOP
   } i2c_state_e;

   localparam logic       I2C_ACK  = 1'b0;
   localparam logic       I2C_NACK = 1'b1;
   localparam int         RW_BIT   = 0;
   localparam logic [2:0] LAST_BIT = 3'd7;

   // An open-drain line can only pull low, so a 0 data bit means "drive".
   function automatic logic od_drive(input logic bit_val);
      return bit_val == 1'b0;
   endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchroniser plus a FILT_LEN-sample glitch filter for one I2C line,
// with single-cycle rise/fall pulses on the filtered level.
module i2c_line_filter #(
   parameter int FILT_LEN = 3
) (
   input  logic iCLK,
   input  logic iRST_N,
   input  logic line_in,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values; reset to 1 matches an idle pulled-up bus.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= line_in;
         sync2 <= sync1;
      end
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         level <= 1'b1;
         cnt   <= '0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == CW'(FILT_LEN - 1)) begin
            level <= sync2;
            cnt   <= '0;
            rise  <= sync2;
            fall  <= ~sync2;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/i2c_cfg_target.sv
// I2C configuration target: address match, register pointer, write strobes
// and pointer-indexed reads, driving SDA open-drain.
module i2c_cfg_target
   import i2c_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR = 7'h1A,
   parameter int         FILT_LEN = 3
) (
   input  logic       iCLK,
   input  logic       iRST_N,
   input  logic       I2C_SCLK,
   inout  wire        I2C_SDAT,
   output logic       oWR_EN,
   output logic [7:0] oWR_ADDR,
   output logic [7:0] oWR_DATA,
   output logic [7:0] oRD_ADDR,
   input  logic [7:0] iRD_DATA,
   output logic       oBUSY
);

   logic scl, scl_rise, scl_fall;
   logic sda, sda_rise, sda_fall;

   i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
      .iCLK(iCLK), .iRST_N(iRST_N), .line_in(I2C_SCLK),
      .level(scl), .rise(scl_rise), .fall(scl_fall)
   );

   i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
      .iCLK(iCLK), .iRST_N(iRST_N), .line_in(I2C_SDAT),
      .level(sda), .rise(sda_rise), .fall(sda_fall)
   );

   i2c_state_e state, state_nxt;
   logic [2:0] bit_cnt;
   logic [7:0] rx_shift;
   logic [6:0] tx_shift;
   logic [7:0] ptr;
   logic       sda_oe, sda_oe_nxt;
   logic       busy;
   logic       bit_adv, rx_shift_en, ptr_load, ptr_inc, wr_fire, tx_load, tx_shift_en;

   wire       start_det = sda_fall && scl;
   wire       stop_det  = sda_rise && scl;
   wire       last_bit  = (bit_cnt == LAST_BIT);
   wire [7:0] rx_byte   = {rx_shift[6:0], sda};

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) state <= ST_IDLE;
      else         state <= state_nxt;
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      if (start_det) begin
         state_nxt = ST_ADDR;
      end else if (stop_det) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_ADDR:
               if (scl_rise && last_bit)
                  state_nxt = (rx_byte[7:1] == DEV_ADDR) ? ST_ADDR_ACK : ST_WAIT_STOP;
            ST_ADDR_ACK:
               if (scl_fall && sda_oe) state_nxt = rx_shift[RW_BIT] ? ST_RDATA : ST_PTR;
            ST_PTR:
               if (scl_rise && last_bit) state_nxt = ST_PTR_ACK;
            ST_PTR_ACK, ST_WDATA_ACK:
               if (scl_fall && sda_oe) state_nxt = ST_WDATA;
            ST_WDATA:
               if (scl_rise && last_bit) state_nxt = ST_WDATA_ACK;
            ST_RDATA:
               if (scl_rise && last_bit) state_nxt = ST_RDATA_ACK;
            ST_RDATA_ACK:
               if (scl_rise) state_nxt = (sda == I2C_NACK) ? ST_WAIT_STOP : ST_RDATA;
            default: ;
         endcase
      end
   end

   // In our own ACK slots sda_oe doubles as the phase: first fall drives, second releases.
   always_comb begin
      bit_adv     = 1'b0;
      rx_shift_en = 1'b0;
      ptr_load    = 1'b0;
      ptr_inc     = 1'b0;
      wr_fire     = 1'b0;
      tx_load     = 1'b0;
      tx_shift_en = 1'b0;
      sda_oe_nxt  = sda_oe;
      if (start_det || stop_det) begin
         sda_oe_nxt = 1'b0;
      end else begin
         case (state)
            ST_ADDR, ST_WDATA: begin
               bit_adv     = scl_rise;
               rx_shift_en = scl_rise;
            end
            ST_PTR: begin
               bit_adv     = scl_rise;
               rx_shift_en = scl_rise;
               ptr_load    = scl_rise && last_bit;
            end
            ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
               if (scl_fall) begin
                  sda_oe_nxt = ~sda_oe;
                  if (state == ST_ADDR_ACK && sda_oe && rx_shift[RW_BIT]) begin
                     tx_load    = 1'b1;
                     sda_oe_nxt = od_drive(iRD_DATA[7]);
                  end
               end
               wr_fire = scl_rise && (state == ST_WDATA_ACK);
               ptr_inc = wr_fire;
            end
            ST_RDATA: begin
               bit_adv = scl_rise;
               if (scl_fall) begin
                  if (bit_cnt == '0) begin
                     tx_load    = 1'b1;
                     sda_oe_nxt = od_drive(iRD_DATA[7]);
                  end else begin
                     tx_shift_en = 1'b1;
                     sda_oe_nxt  = od_drive(tx_shift[6]);
                  end
               end
            end
            ST_RDATA_ACK: begin
               if (scl_fall) sda_oe_nxt = 1'b0;
               ptr_inc = scl_rise && (sda == I2C_ACK);
            end
            default: sda_oe_nxt = 1'b0;
         endcase
      end
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         bit_cnt  <= '0;
         rx_shift <= '0;
         tx_shift <= '0;
         ptr      <= '0;
         sda_oe   <= 1'b0;
         busy     <= 1'b0;
         oWR_EN   <= 1'b0;
         oWR_ADDR <= '0;
         oWR_DATA <= '0;
      end else begin
         oWR_EN <= wr_fire;
         sda_oe <= sda_oe_nxt;

         if (start_det)     busy <= 1'b1;
         else if (stop_det) busy <= 1'b0;

         if (start_det || stop_det) bit_cnt <= '0;
         else if (bit_adv)          bit_cnt <= bit_cnt + 1'b1;

         if (rx_shift_en) rx_shift <= rx_byte;

         if (tx_load)          tx_shift <= iRD_DATA[6:0];
         else if (tx_shift_en) tx_shift <= {tx_shift[5:0], 1'b0};

         if (wr_fire) begin
            oWR_ADDR <= ptr;
            oWR_DATA <= rx_shift;
         end

         if (ptr_load)     ptr <= rx_byte;
         else if (ptr_inc) ptr <= ptr + 1'b1;
      end
   end

   assign I2C_SDAT = sda_oe ? 1'b0 : 1'bz;
   assign oRD_ADDR = ptr;
   assign oBUSY    = busy;

endmodule

// File: tb/tb_i2c_cfg_target.sv
// Bench for i2c_cfg_target: bit-banged I2C master, pulled-up SDA, write monitor,
// a table of single-write transactions and hand-written multi-cycle sequences.
module tb_i2c_cfg_target;

   localparam int Q = 10;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       scl_drv;
   logic       sda_low;
   logic       glitch_en;
   wire        sda_bus;
   logic       wr_en;
   logic [7:0] wr_addr, wr_data, rd_addr, rd_data;
   logic       busy;
   logic [7:0] rd_mem [256];

   always #5 clk = ~clk;

   pullup (sda_bus);
   assign sda_bus = sda_low ? 1'b0 : 1'bz;
   assign rd_data = rd_mem[rd_addr];

   i2c_cfg_target dut (
      .iCLK(clk), .iRST_N(rst_n), .I2C_SCLK(scl_drv), .I2C_SDAT(sda_bus),
      .oWR_EN(wr_en), .oWR_ADDR(wr_addr), .oWR_DATA(wr_data),
      .oRD_ADDR(rd_addr), .iRD_DATA(rd_data), .oBUSY(busy)
   );

   int          n_checks = 0;
   int          n_pass   = 0;
   int          cyc      = 0;
   int          mark_cyc = 0;
   int          max_lat  = 0;
   logic [15:0] wr_log[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (wr_en) begin
         wr_log.push_back({wr_addr, wr_data});
         if (cyc - mark_cyc > max_lat) max_lat = cyc - mark_cyc;
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached before the summary");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Waits Q clocks, optionally toggling SCL for a single clock in the middle.
   task automatic hold_phase();
      if (glitch_en) begin
         wait_clk(Q / 2);
         scl_drv = ~scl_drv;
         wait_clk(1);
         scl_drv = ~scl_drv;
         wait_clk(Q - Q / 2 - 1);
      end else begin
         wait_clk(Q);
      end
   endtask

   task automatic i2c_start();
      sda_low = 1'b0; wait_clk(Q);
      scl_drv = 1'b1; wait_clk(Q);
      sda_low = 1'b1; wait_clk(Q);
      scl_drv = 1'b0; wait_clk(Q);
   endtask

   task automatic i2c_stop();
      sda_low = 1'b1; wait_clk(Q);
      scl_drv = 1'b1; wait_clk(Q);
      sda_low = 1'b0; wait_clk(Q);
   endtask

   task automatic send_bit(input logic b);
      sda_low = ~b;   hold_phase();
      scl_drv = 1'b1; hold_phase(); wait_clk(Q);
      scl_drv = 1'b0; wait_clk(Q);
   endtask

   task automatic ack_slot(output logic ack);
      sda_low  = 1'b0; wait_clk(Q);
      scl_drv  = 1'b1;
      mark_cyc = cyc;  wait_clk(Q);
      ack      = sda_bus; wait_clk(Q);
      scl_drv  = 1'b0; wait_clk(Q);
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
      ack_slot(ack);
   endtask

   task automatic read_byte(input logic master_ack, output logic [7:0] b);
      for (int i = 7; i >= 0; i--) begin
         sda_low = 1'b0; wait_clk(Q);
         scl_drv = 1'b1; wait_clk(Q);
         b[i]    = sda_bus; wait_clk(Q);
         scl_drv = 1'b0; wait_clk(Q);
      end
      sda_low = master_ack; wait_clk(Q);
      scl_drv = 1'b1;       wait_clk(2 * Q);
      scl_drv = 1'b0;       wait_clk(Q);
      sda_low = 1'b0;
   endtask

   typedef struct {
      logic [7:0]  dev;
      logic [7:0]  ptr;
      logic [7:0]  data;
      logic        ack_line;   // SDA level expected in every ACK slot
      int          n_wr;
      logic [15:0] exp_wr;     // {oWR_ADDR, oWR_DATA}
   } wr_vec_t;

   wr_vec_t vecs[6];

   initial begin
      logic        a0, a1, a2;
      logic [7:0]  rb;
      logic [15:0] exp_burst[3];

      vecs[0] = '{8'h34, 8'h0E, 8'h01, 1'b0, 1, 16'h0E01};
      vecs[1] = '{8'h40, 8'h0E, 8'h01, 1'b1, 0, 16'h0000};
      vecs[2] = '{8'h34, 8'h00, 8'hFF, 1'b0, 1, 16'h00FF};
      vecs[3] = '{8'h36, 8'h22, 8'h33, 1'b1, 0, 16'h0000};
      vecs[4] = '{8'h34, 8'hFF, 8'h5A, 1'b0, 1, 16'hFF5A};
      vecs[5] = '{8'h1A, 8'h44, 8'h55, 1'b1, 0, 16'h0000};
      exp_burst[0] = 16'hFEAA;
      exp_burst[1] = 16'hFFBB;
      exp_burst[2] = 16'h00CC;

      for (int i = 0; i < 256; i++) rd_mem[i] = 8'h00;
      rd_mem[8'h10] = 8'h5A;
      rd_mem[8'h11] = 8'hC3;

      rst_n = 1'b0; scl_drv = 1'b1; sda_low = 1'b0; glitch_en = 1'b0;
      wait_clk(5);
      check("rst wr_en",   wr_en,   0);
      check("rst wr_addr", wr_addr, 0);
      check("rst wr_data", wr_data, 0);
      check("rst rd_addr", rd_addr, 0);
      check("rst busy",    busy,    0);
      check("rst sda",     sda_bus, 1);
      rst_n = 1'b1;
      wait_clk(5);

      // Single-write transactions, matching and foreign addresses.
      for (int v = 0; v < 6; v++) begin
         wr_log.delete();
         i2c_start();
         write_byte(vecs[v].dev,  a0);
         write_byte(vecs[v].ptr,  a1);
         write_byte(vecs[v].data, a2);
         check($sformatf("v%0d busy_mid", v), busy, 1);
         i2c_stop();
         wait_clk(Q);
         check($sformatf("v%0d ack_dev", v),  a0, vecs[v].ack_line);
         check($sformatf("v%0d ack_ptr", v),  a1, vecs[v].ack_line);
         check($sformatf("v%0d ack_data", v), a2, vecs[v].ack_line);
         check($sformatf("v%0d busy_end", v), busy, 0);
         check($sformatf("v%0d sda_end", v),  sda_bus, 1);
         check($sformatf("v%0d n_wr", v), wr_log.size(), vecs[v].n_wr);
         if (vecs[v].n_wr == 1 && wr_log.size() == 1)
            check($sformatf("v%0d wr", v), wr_log[0], vecs[v].exp_wr);
      end

      // Burst write with pointer wrap.
      wr_log.delete();
      i2c_start();
      write_byte(8'h34, a0);
      write_byte(8'hFE, a1);
      check("burst ack_dev", a0, 0);
      check("burst ack_ptr", a1, 0);
      write_byte(8'hAA, a0);
      write_byte(8'hBB, a1);
      write_byte(8'hCC, a2);
      check("burst ack_data", {a0, a1, a2}, 3'b000);
      i2c_stop();
      wait_clk(Q);
      check("burst n_wr", wr_log.size(), 3);
      for (int i = 0; i < 3; i++)
         if (i < wr_log.size()) check($sformatf("burst wr%0d", i), wr_log[i], exp_burst[i]);
      check("burst rd_addr_wrap", rd_addr, 8'h01);

      // Pointer write, repeated START, two-byte read.
      wr_log.delete();
      i2c_start();
      write_byte(8'h34, a0);
      write_byte(8'h10, a1);
      check("rd ack_w", {a0, a1}, 2'b00);
      check("rd rd_addr_0", rd_addr, 8'h10);
      i2c_start();
      write_byte(8'h35, a0);
      check("rd ack_r", a0, 0);
      read_byte(1'b1, rb);
      check("rd byte0", rb, 8'h5A);
      check("rd rd_addr_1", rd_addr, 8'h11);
      read_byte(1'b0, rb);
      check("rd byte1", rb, 8'hC3);
      check("rd rd_addr_nack", rd_addr, 8'h11);
      i2c_stop();
      wait_clk(Q);
      check("rd busy_end", busy, 0);
      check("rd n_wr", wr_log.size(), 0);

      // STOP after four data bits, then a normal transfer.
      wr_log.delete();
      i2c_start();
      write_byte(8'h34, a0);
      write_byte(8'h20, a1);
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
      i2c_stop();
      wait_clk(Q);
      check("partial n_wr", wr_log.size(), 0);
      check("partial sda",  sda_bus, 1);
      check("partial busy", busy, 0);
      i2c_start();
      write_byte(8'h34, a0);
      write_byte(8'h21, a1);
      write_byte(8'h55, a2);
      i2c_stop();
      wait_clk(Q);
      check("recover acks", {a0, a1, a2}, 3'b000);
      check("recover n_wr", wr_log.size(), 1);
      if (wr_log.size() == 1) check("recover wr", wr_log[0], 16'h2155);

      // Single-clock SCL glitches throughout the data bits.
      wr_log.delete();
      glitch_en = 1'b1;
      i2c_start();
      write_byte(8'h34, a0);
      write_byte(8'h30, a1);
      write_byte(8'hA5, a2);
      i2c_stop();
      glitch_en = 1'b0;
      wait_clk(Q);
      check("glitch acks", {a0, a1, a2}, 3'b000);
      check("glitch n_wr", wr_log.size(), 1);
      if (wr_log.size() == 1) check("glitch wr", wr_log[0], 16'h30A5);

      // Reset asserted while the target holds SDA low in an ACK slot.
      i2c_start();
      write_byte(8'h34, a0);
      for (int i = 7; i >= 0; i--) send_bit(1'b0);
      sda_low = 1'b0;
      check("arst ack_driven", sda_bus, 0);
      scl_drv = 1'b1;
      wait_clk(Q / 2);
      rst_n = 1'b0;
      #1;
      check("arst sda_released", sda_bus, 1);
      check("arst busy", busy, 0);
      wait_clk(3);
      rst_n = 1'b1;
      wait_clk(Q);
      wr_log.delete();
      i2c_start();
      write_byte(8'h34, a0);
      write_byte(8'h40, a1);
      write_byte(8'h77, a2);
      i2c_stop();
      wait_clk(Q);
      check("arst recover_acks", {a0, a1, a2}, 3'b000);
      check("arst recover_n_wr", wr_log.size(), 1);
      if (wr_log.size() == 1) check("arst recover_wr", wr_log[0], 16'h4077);

      check("wr_latency_le_6", (max_lat >= 1 && max_lat <= 6), 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
